io_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares the single slave port of the I/O bridge between NREQ Wishbone-classic requesters (CPU data, CPU fetch, DMA, debug).
- Owns the bus from grant until the owner releases it.
- Registers all master-side outputs and adds a bus-timeout watchdog, so a dead I/O device cannot hang a requester.
- Sits between the requester ports and the I/O bridge s1 port.

---
 rtl/io_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the I/O bridge slave port between NREQ Wishbone-classic
// requesters, with registered master-side outputs and a WAIT_ACK timeout watchdog.
module io_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      s_cyc_i,
    input  logic [NREQ-1:0]      s_stb_i,
    input  logic [NREQ-1:0]      s_we_i,
    input  logic [4*NREQ-1:0]    s_sel_i,
    input  logic [32*NREQ-1:0]   s_adr_i,
    input  logic [32*NREQ-1:0]   s_dat_i,
    output logic [NREQ-1:0]      s_ack_o,
    output logic [NREQ-1:0]      s_err_o,
    output logic [31:0]          s_dat_o,
    output logic                 m_cyc_o,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [3:0]           m_sel_o,
    output logic [31:0]          m_adr_o,
    output logic [31:0]          m_dat_o,
    input  logic                 m_ack_i,
    input  logic [31:0]          m_dat_i,
    output logic [IW-1:0]        gnt_o,
    output logic                 busy_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    // Master bus packed as {cyc, stb, we, sel, adr, dat} so it can be latched or cleared as one.
    localparam int MBW = 71;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MBW-1:0]  m_bus_q, m_bus_d;
    logic [NREQ-1:0] s_ack_q, s_ack_d;
    logic [NREQ-1:0] s_err_q, s_err_d;
    logic [31:0]     s_dat_q, s_dat_d;

    logic [NREQ-1:0] req;
    logic            found;
    logic [IW-1:0]   win;
    int              idx;
    logic [IW-1:0]   nxt_ptr;
    logic [NREQ-1:0] own_mask;
    logic            own_cyc;
    logic            own_stb;

    // Round-robin search: start at ptr_q, wrap modulo NREQ, first requester wins.
    always_comb begin
        req   = s_cyc_i & s_stb_i;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        nxt_ptr  = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        own_mask = NREQ'(1) << gnt_q;
        own_cyc  = s_cyc_i[gnt_q];
        own_stb  = s_stb_i[gnt_q];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        m_bus_d = m_bus_q;
        s_ack_d = s_ack_q;
        s_err_d = s_err_q;
        s_dat_d = s_dat_q;
        case (state_q)
            ST_IDLE: begin
                // A stale ack still on the bridge would be taken for the new cycle's ack.
                if (!m_ack_i && found) begin
                    gnt_d   = win;
                    m_bus_d = {2'b11, s_we_i[win], s_sel_i[4*int'(win) +: 4],
                               s_adr_i[32*int'(win) +: 32], s_dat_i[32*int'(win) +: 32]};
                    cnt_d   = '0;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!own_cyc) begin
                    m_bus_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = ST_IDLE;
                end else if (m_ack_i) begin
                    s_dat_d = m_dat_i;
                    s_ack_d = own_mask;
                    m_bus_d = '0;
                    state_d = ST_WAIT_REL;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    s_err_d = own_mask;
                    m_bus_d = '0;
                    state_d = ST_WAIT_REL;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!own_stb || !own_cyc) begin
                    s_ack_d = '0;
                    s_err_d = '0;
                    s_dat_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            m_bus_q <= '0;
            s_ack_q <= '0;
            s_err_q <= '0;
            s_dat_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            m_bus_q <= m_bus_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_dat_q <= s_dat_d;
        end
    end

    assign m_cyc_o = m_bus_q[70];
    assign m_stb_o = m_bus_q[69];
    assign m_we_o  = m_bus_q[68];
    assign m_sel_o = m_bus_q[67:64];
    assign m_adr_o = m_bus_q[63:32];
    assign m_dat_o = m_bus_q[31:0];
    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_dat_o = s_dat_q;
    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: vector table of single transactions, a scoreboard of
// expected {ack, read data}, and hand-written sequences for the multi-cycle corners.
module tb_io_bus_arbiter;

    localparam int NREQ = 4;

    logic         clk;
    logic         rst_ni;
    logic [3:0]   s_cyc_i, s_stb_i, s_we_i;
    logic [15:0]  s_sel_i;
    logic [127:0] s_adr_i, s_dat_i;
    logic [3:0]   s_ack_o, s_err_o;
    logic [31:0]  s_dat_o;
    logic         m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]   m_sel_o;
    logic [31:0]  m_adr_o, m_dat_o;
    logic         m_ack_i;
    logic [31:0]  m_dat_i;
    logic [1:0]   gnt_o;
    logic         busy_o;

    io_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(16), .CW(8)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_dat_o(s_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i), .m_dat_i(m_dat_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        int          k;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          delay;
        logic [31:0] rdat;
        logic [1:0]  exp_gnt;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
        s_cyc_i[k] = 1'b1;
        s_stb_i[k] = 1'b1;
        s_we_i[k]  = we;
        s_sel_i[4*k +: 4]   = sel;
        s_adr_i[32*k +: 32] = adr;
        s_dat_i[32*k +: 32] = dat;
    endtask

    task automatic drop_req(input int k);
        s_cyc_i[k] = 1'b0;
        s_stb_i[k] = 1'b0;
    endtask

    // Bridge answers; expected slave-side response goes on the scoreboard.
    task automatic ack_and_check(input logic [3:0] exp_ack, input logic [31:0] rdata);
        logic [35:0] e;
        m_ack_i = 1'b1;
        m_dat_i = rdata;
        exp_q.push_back({exp_ack, rdata});
        tick;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("ack_data", {s_ack_o, s_dat_o}, e);
        end
        check("bus_clear_after_ack", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}, 0);
        check("err_on_ack", s_err_o, 0);
    endtask

    task automatic release_and_check(input int k);
        drop_req(k);
        tick;
        check("release", {s_ack_o, s_err_o, s_dat_o, busy_o}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        set_req(v.k, v.we, v.sel, v.adr, v.wdat);
        tick;
        check("grant_cyc", {m_cyc_o, m_stb_o, busy_o}, 3'b111);
        check("grant_idx", gnt_o, v.exp_gnt);
        check("grant_bus", {m_we_o, m_sel_o, m_adr_o, m_dat_o}, {v.we, v.sel, v.adr, v.wdat});
        s_adr_i[32*v.k +: 32] = ~v.adr;
        repeat (v.delay) tick;
        check("latched_adr", {m_cyc_o, m_adr_o}, {1'b1, v.adr});
        ack_and_check(v.exp_ack, v.rdat);
        release_and_check(v.k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int          cyc_cycles;
        int          guard;
        logic        ack_seen;
        logic [1:0]  eg;
        logic [31:0] rd;

        vecs[0] = '{k: 2, we: 1'b0, sel: 4'hf, adr: 32'hFD000010, wdat: 32'h0,        delay: 3, rdat: 32'h12345678, exp_gnt: 2'd2, exp_ack: 4'b0100};
        vecs[1] = '{k: 0, we: 1'b1, sel: 4'h3, adr: 32'hFD000020, wdat: 32'hCAFEBABE, delay: 1, rdat: 32'h0BADF00D, exp_gnt: 2'd0, exp_ack: 4'b0001};
        vecs[2] = '{k: 3, we: 1'b1, sel: 4'h8, adr: 32'hFD0000FC, wdat: 32'h11223344, delay: 5, rdat: 32'hA5A5A5A5, exp_gnt: 2'd3, exp_ack: 4'b1000};
        vecs[3] = '{k: 1, we: 1'b0, sel: 4'hc, adr: 32'h00000004, wdat: 32'hFFFFFFFF, delay: 2, rdat: 32'hDEADBEEF, exp_gnt: 2'd1, exp_ack: 4'b0010};
        vecs[4] = '{k: 2, we: 1'b1, sel: 4'h1, adr: 32'hFFFFFFFC, wdat: 32'h00000001, delay: 4, rdat: 32'h00000000, exp_gnt: 2'd2, exp_ack: 4'b0100};
        vecs[5] = '{k: 0, we: 1'b0, sel: 4'hf, adr: 32'h80000000, wdat: 32'h5A5A5A5A, delay: 1, rdat: 32'hFFFFFFFF, exp_gnt: 2'd0, exp_ack: 4'b0001};

        // Reset
        rst_ni  = 1'b0;
        s_cyc_i = '0; s_stb_i = '0; s_we_i = '0; s_sel_i = '0;
        s_adr_i = '0; s_dat_i = '0;
        m_ack_i = 1'b0; m_dat_i = '0;
        repeat (3) tick;
        check("reset_outputs", {s_ack_o, s_err_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
                                m_adr_o, m_dat_o, gnt_o, busy_o}, 0);
        rst_ni = 1'b1;
        tick;

        // Fairness: everyone requests continuously, grants rotate from 0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'hf, 32'h100 * i, 32'h0);
        for (int t = 0; t < 8; t++) begin
            eg = 2'(t % NREQ);
            tick;
            check("rr_gnt", gnt_o, eg);
            check("rr_adr", {m_cyc_o, m_adr_o}, {1'b1, 32'h100 * eg});
            rd = $urandom;
            ack_and_check(4'(1 << eg), rd);
            s_stb_i[eg] = 1'b0;
            tick;
            check("rr_release", {s_ack_o, s_err_o, busy_o}, 0);
            s_stb_i[eg] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) drop_req(i);
        tick;

        // Single-requester vector table
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Timeout: bridge never acks
        set_req(1, 1'b0, 4'hf, 32'hFD000100, 32'h0);
        tick;
        cyc_cycles = 0;
        guard      = 0;
        ack_seen   = 1'b0;
        while (m_cyc_o && guard < 40) begin
            cyc_cycles++;
            ack_seen |= |s_ack_o;
            tick;
            guard++;
        end
        check("timeout_cycles", cyc_cycles, 16);
        check("timeout_err", {s_err_o, s_ack_o, ack_seen, m_cyc_o, busy_o}, {4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1});
        s_stb_i[1] = 1'b0;
        tick;
        check("timeout_release", {s_ack_o, s_err_o, busy_o}, 0);
        s_cyc_i[1] = 1'b0;

        // Owner abort racing the bridge ack (ptr is 2 here)
        set_req(1, 1'b0, 4'hf, 32'hFD000200, 32'h0);
        tick;
        check("abort_gnt", {gnt_o, m_cyc_o}, {2'd1, 1'b1});
        m_ack_i = 1'b1;
        m_dat_i = 32'h77777777;
        drop_req(1);
        tick;
        check("abort_no_ack", {s_ack_o, s_err_o, s_dat_o, busy_o, m_cyc_o}, 0);
        m_ack_i = 1'b0;
        m_dat_i = '0;
        set_req(0, 1'b0, 4'hf, 32'h0, 32'h0);
        set_req(3, 1'b0, 4'hf, 32'h3, 32'h0);
        tick;
        check("abort_ptr_adv", gnt_o, 2'd3);
        ack_and_check(4'b1000, 32'h33333333);
        drop_req(0);
        release_and_check(3);

        // Stale ack in IDLE blocks the grant (ptr is 0 here)
        m_ack_i = 1'b1;
        set_req(1, 1'b1, 4'hf, 32'hFD000300, 32'h01010101);
        repeat (3) tick;
        check("stale_ack_hold", {busy_o, m_cyc_o}, 0);
        m_ack_i = 1'b0;
        tick;
        check("stale_ack_grant", {gnt_o, m_cyc_o}, {2'd1, 1'b1});
        ack_and_check(4'b0010, 32'h44444444);
        release_and_check(1);

        // cyc without stb is not a request
        s_cyc_i[2] = 1'b1;
        repeat (2) tick;
        check("cyc_no_stb", {busy_o, m_cyc_o}, 0);
        s_cyc_i[2] = 1'b0;

        // Reset during WAIT_ACK (ptr is 2 here)
        set_req(3, 1'b0, 4'hf, 32'hFD000400, 32'h0);
        tick;
        check("pre_reset_gnt", {gnt_o, busy_o}, {2'd3, 1'b1});
        rst_ni = 1'b0;
        tick;
        check("midtxn_reset", {s_ack_o, s_err_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
                               m_adr_o, m_dat_o, gnt_o, busy_o}, 0);
        rst_ni = 1'b1;
        set_req(0, 1'b0, 4'hf, 32'hFD000500, 32'h0);
        tick;
        check("post_reset_gnt", {gnt_o, m_cyc_o, m_adr_o}, {2'd0, 1'b1, 32'hFD000500});
        ack_and_check(4'b0001, 32'h55555555);
        drop_req(3);
        release_and_check(0);

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
